// File: rtl/mctrl_pkg.sv
// Shared types and constants for the multi-cycle MIPS control sequencer.
package mctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_EXECUTE   = 4'd6,
    S_R_WB      = 4'd7,
    S_BRANCH    = 4'd8,
    S_JUMP      = 4'd9,
    S_ADDI_EX   = 4'd10,
    S_ADDI_WB   = 4'd11,
    S_HALT      = 4'd15
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_ADDI  = 6'h08;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_B       = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  function automatic logic is_known_op(input logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
           (op == OP_BEQ) || (op == OP_J) || (op == OP_ADDI);
  endfunction

endpackage

// File: rtl/mctrl_out_decode.sv
// Moore output decode for the multi-cycle sequencer; reset forces every control low.
// MCTRL_ILLEGAL_TRAP_EN enables the halted output in the HALT state.
module mctrl_out_decode
  import mctrl_pkg::*;
(
  input  logic [3:0] state,
  input  logic       mem_ready,
  input  logic       rst,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       ir_write,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       reg_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] pc_source,
  output logic       retire,
  output logic       halted
);

  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    ir_write      = 1'b0;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    reg_write     = 1'b0;
    reg_dst       = 1'b0;
    mem_to_reg    = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = SRCB_B;
    alu_op        = ALU_ADD;
    pc_source     = PCSRC_ALU;
    retire        = 1'b0;
    halted        = 1'b0;
    if (!rst) begin
      unique case (state_t'(state))
        S_FETCH: begin
          mem_read  = 1'b1;
          alu_src_b = SRCB_FOUR;
          ir_write  = mem_ready;
          pc_write  = mem_ready;
        end
        S_DECODE:   alu_src_b = SRCB_IMM_SH2;
        S_MEM_ADDR: begin
          alu_src_a = 1'b1;
          alu_src_b = SRCB_IMM;
        end
        S_MEM_READ: begin
          mem_read = 1'b1;
          i_or_d   = 1'b1;
        end
        S_MEM_WB: begin
          reg_write  = 1'b1;
          mem_to_reg = 1'b1;
          retire     = 1'b1;
        end
        S_MEM_WRITE: begin
          mem_write = 1'b1;
          i_or_d    = 1'b1;
          retire    = mem_ready;
        end
        S_EXECUTE: begin
          alu_src_a = 1'b1;
          alu_op    = ALU_FUNCT;
        end
        S_R_WB: begin
          reg_write = 1'b1;
          reg_dst   = 1'b1;
          retire    = 1'b1;
        end
        S_BRANCH: begin
          alu_src_a     = 1'b1;
          alu_op        = ALU_SUB;
          pc_write_cond = 1'b1;
          pc_source     = PCSRC_ALUOUT;
          retire        = 1'b1;
        end
        S_JUMP: begin
          pc_write  = 1'b1;
          pc_source = PCSRC_JUMP;
          retire    = 1'b1;
        end
        S_ADDI_EX: begin
          alu_src_a = 1'b1;
          alu_src_b = SRCB_IMM;
        end
        S_ADDI_WB: begin
          reg_write = 1'b1;
          retire    = 1'b1;
        end
`ifdef MCTRL_ILLEGAL_TRAP_EN
        S_HALT: halted = 1'b1;
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// Multi-cycle MIPS control sequencer: state register, next-state logic, retire counter.
// MCTRL_ILLEGAL_TRAP_EN: unknown opcodes trap into HALT instead of retiring as a NOP.
module multicycle_ctrl_fsm
  import mctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       instr_opcode,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             pc_write_cond,
  output logic             ir_write,
  output logic             i_or_d,
  output logic             mem_read,
  output logic             mem_write,
  output logic             reg_write,
  output logic             reg_dst,
  output logic             mem_to_reg,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic [1:0]       pc_source,
  output logic             retire,
  output logic [CNT_W-1:0] retire_count,
  output logic [3:0]       state_dbg,
  output logic             halted
);

  state_t             state_reg, state_next;
  logic               is_sw_reg;
  logic [CNT_W-1:0]   retire_count_reg;
  logic               dec_retire;
  logic               nop_retire;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg        <= S_FETCH;
      retire_count_reg <= '0;
      is_sw_reg        <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (retire)
        retire_count_reg <= retire_count_reg + CNT_W'(1);
      // MEM_ADDR needs lw/sw after the opcode window has closed
      if (state_reg == S_DECODE)
        is_sw_reg <= (instr_opcode == OP_SW);
    end
  end

  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      S_FETCH:     if (mem_ready) state_next = S_DECODE;
      S_DECODE: begin
        unique case (instr_opcode)
          OP_RTYPE:     state_next = S_EXECUTE;
          OP_LW, OP_SW: state_next = S_MEM_ADDR;
          OP_BEQ:       state_next = S_BRANCH;
          OP_J:         state_next = S_JUMP;
          OP_ADDI:      state_next = S_ADDI_EX;
`ifdef MCTRL_ILLEGAL_TRAP_EN
          default:      state_next = S_HALT;
`else
          default:      state_next = S_FETCH;
`endif
        endcase
      end
      S_MEM_ADDR:  state_next = is_sw_reg ? S_MEM_WRITE : S_MEM_READ;
      S_MEM_READ:  if (mem_ready) state_next = S_MEM_WB;
      S_MEM_WRITE: if (mem_ready) state_next = S_FETCH;
      S_EXECUTE:   state_next = S_R_WB;
      S_ADDI_EX:   state_next = S_ADDI_WB;
      S_HALT:      state_next = S_HALT;
      default:     state_next = S_FETCH;
    endcase
  end

`ifdef MCTRL_ILLEGAL_TRAP_EN
  assign nop_retire = 1'b0;
`else
  // Unknown opcodes complete as a NOP in DECODE and still count as retired
  assign nop_retire = !rst && (state_reg == S_DECODE) && !is_known_op(instr_opcode);
`endif

  mctrl_out_decode u_out_decode (
    .state         (state_reg),
    .mem_ready     (mem_ready),
    .rst           (rst),
    .pc_write      (pc_write),
    .pc_write_cond (pc_write_cond),
    .ir_write      (ir_write),
    .i_or_d        (i_or_d),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .reg_write     (reg_write),
    .reg_dst       (reg_dst),
    .mem_to_reg    (mem_to_reg),
    .alu_src_a     (alu_src_a),
    .alu_src_b     (alu_src_b),
    .alu_op        (alu_op),
    .pc_source     (pc_source),
    .retire        (dec_retire),
    .halted        (halted)
  );

  assign retire       = dec_retire | nop_retire;
  assign retire_count = retire_count_reg;
  assign state_dbg    = state_reg;

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Directed self-checking bench for multicycle_ctrl_fsm (4-bit retire counter to exercise wrap).
module tb_multicycle_ctrl_fsm;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] instr_opcode;
  logic       mem_ready;
  logic       pc_write, pc_write_cond, ir_write, i_or_d, mem_read, mem_write;
  logic       reg_write, reg_dst, mem_to_reg, alu_src_a;
  logic [1:0] alu_src_b, alu_op, pc_source;
  logic       retire, halted;
  logic [3:0] retire_count;
  logic [3:0] state_dbg;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  multicycle_ctrl_fsm #(.CNT_W(4)) dut (
    .clk(clk), .rst(rst), .instr_opcode(instr_opcode), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .ir_write(ir_write),
    .i_or_d(i_or_d), .mem_read(mem_read), .mem_write(mem_write),
    .reg_write(reg_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .pc_source(pc_source), .retire(retire), .retire_count(retire_count),
    .state_dbg(state_dbg), .halted(halted)
  );

  // pcw pcwc irw iord mrd mwr rw rdst m2r asa | asb | aop | psrc | retire halted
  logic [17:0] ctl;
  assign ctl = {pc_write, pc_write_cond, ir_write, i_or_d, mem_read, mem_write,
                reg_write, reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_op,
                pc_source, retire, halted};

  localparam logic [17:0] E_ZERO   = 18'h0;
  localparam logic [17:0] E_FETCH  = {1'b1,1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,2'b01,2'b00,2'b00,1'b0,1'b0};
  localparam logic [17:0] E_FWAIT  = {1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,2'b01,2'b00,2'b00,1'b0,1'b0};
  localparam logic [17:0] E_DEC    = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b11,2'b00,2'b00,1'b0,1'b0};
  localparam logic [17:0] E_DECNOP = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b11,2'b00,2'b00,1'b1,1'b0};
  localparam logic [17:0] E_MADDR  = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b10,2'b00,2'b00,1'b0,1'b0};
  localparam logic [17:0] E_MRD    = {1'b0,1'b0,1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,2'b00,1'b0,1'b0};
  localparam logic [17:0] E_MWB    = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,2'b00,2'b00,2'b00,1'b1,1'b0};
  localparam logic [17:0] E_MWR    = {1'b0,1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,2'b00,1'b1,1'b0};
  localparam logic [17:0] E_MWWAIT = {1'b0,1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,2'b00,1'b0,1'b0};
  localparam logic [17:0] E_EXE    = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,2'b10,2'b00,1'b0,1'b0};
  localparam logic [17:0] E_RWB    = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b1,1'b0,1'b0,2'b00,2'b00,2'b00,1'b1,1'b0};
  localparam logic [17:0] E_BR     = {1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,2'b01,2'b01,1'b1,1'b0};
  localparam logic [17:0] E_JMP    = {1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,2'b10,1'b1,1'b0};
  localparam logic [17:0] E_AEX    = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b10,2'b00,2'b00,1'b0,1'b0};
  localparam logic [17:0] E_AWB    = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,2'b00,2'b00,2'b00,1'b1,1'b0};
  localparam logic [17:0] E_HALT   = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,2'b00,1'b0,1'b1};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs are set just after a rising edge; check the current cycle, then advance one cycle.
  task automatic step(input string tag, input logic [3:0] st, input logic [17:0] ec);
    #1;
    chk({tag, "/state"}, 32'(state_dbg), 32'(st));
    chk({tag, "/ctl"}, 32'(ctl), 32'(ec));
    $display("step %-10s state=%0d ctl=%05h retire_count=%0d", tag, state_dbg, ctl, retire_count);
    @(posedge clk); #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; mem_ready = 1'b1; instr_opcode = 6'h00;
    @(posedge clk); #1;
    chk("rst_c0_ctl", 32'(ctl), 32'(E_ZERO));
    @(posedge clk); #1;
    chk("rst_c1_ctl", 32'(ctl), 32'(E_ZERO));
    rst = 1'b0;
    #1;
    chk("rst_cnt", 32'(retire_count), 32'd0);
    step("rst_fetch", 4'd0, E_FETCH);
    // the DECODE that follows sees opcode 0 -> R-type
    step("r0_dec", 4'd1, E_DEC);
    step("r0_exe", 4'd6, E_EXE);
    step("r0_wb", 4'd7, E_RWB);
    chk("r0_cnt", 32'(retire_count), 32'd1);

    // lw, no waits: 0,1,2,3,4
    instr_opcode = 6'h23;
    step("lw_f", 4'd0, E_FETCH);
    step("lw_d", 4'd1, E_DEC);
    step("lw_a", 4'd2, E_MADDR);
    step("lw_r", 4'd3, E_MRD);
    step("lw_wb", 4'd4, E_MWB);
    chk("lw_cnt", 32'(retire_count), 32'd2);

    // lw with 2 FETCH waits and 3 MEM_READ waits: 10 cycles
    mem_ready = 1'b0;
    step("lww_f0", 4'd0, E_FWAIT);
    step("lww_f1", 4'd0, E_FWAIT);
    mem_ready = 1'b1;
    step("lww_f2", 4'd0, E_FETCH);
    step("lww_d", 4'd1, E_DEC);
    step("lww_a", 4'd2, E_MADDR);
    mem_ready = 1'b0;
    step("lww_r0", 4'd3, E_MRD);
    step("lww_r1", 4'd3, E_MRD);
    step("lww_r2", 4'd3, E_MRD);
    mem_ready = 1'b1;
    step("lww_r3", 4'd3, E_MRD);
    step("lww_wb", 4'd4, E_MWB);
    chk("lww_cnt", 32'(retire_count), 32'd3);

    // sw with one wait in MEM_WRITE
    instr_opcode = 6'h2B;
    step("sw_f", 4'd0, E_FETCH);
    step("sw_d", 4'd1, E_DEC);
    step("sw_a", 4'd2, E_MADDR);
    mem_ready = 1'b0;
    step("sw_w0", 4'd5, E_MWWAIT);
    mem_ready = 1'b1;
    step("sw_w1", 4'd5, E_MWR);
    chk("sw_cnt", 32'(retire_count), 32'd4);

    // beq then j
    instr_opcode = 6'h04;
    step("beq_f", 4'd0, E_FETCH);
    step("beq_d", 4'd1, E_DEC);
    instr_opcode = 6'h02;
    step("beq_br", 4'd8, E_BR);
    step("j_f", 4'd0, E_FETCH);
    step("j_d", 4'd1, E_DEC);
    step("j_j", 4'd9, E_JMP);
    chk("bj_cnt", 32'(retire_count), 32'd6);

    // addi, with a stray mem_ready=0 outside memory states
    instr_opcode = 6'h08;
    step("addi_f", 4'd0, E_FETCH);
    mem_ready = 1'b0;
    step("addi_d", 4'd1, E_DEC);
    step("addi_ex", 4'd10, E_AEX);
    mem_ready = 1'b1;
    step("addi_wb", 4'd11, E_AWB);
    chk("addi_cnt", 32'(retire_count), 32'd7);

    // illegal opcode
    instr_opcode = 6'h3F;
    step("ill_f", 4'd0, E_FETCH);
`ifdef MCTRL_ILLEGAL_TRAP_EN
    step("ill_d", 4'd1, E_DEC);
    step("ill_h0", 4'd15, E_HALT);
    step("ill_h1", 4'd15, E_HALT);
    step("ill_h2", 4'd15, E_HALT);
    chk("ill_cnt", 32'(retire_count), 32'd7);
    rst = 1'b1;
    #1;
    chk("ill_rst_ctl", 32'(ctl), 32'(E_ZERO));
    @(posedge clk); #1;
    rst = 1'b0;
    chk("ill_rst_cnt", 32'(retire_count), 32'd0);
`else
    step("ill_d", 4'd1, E_DECNOP);
    #1;
    chk("ill_back", 32'(state_dbg), 32'd0);
    chk("ill_cnt", 32'(retire_count), 32'd8);
    #1;
`endif

    // reset in the middle of a lw abandons it without a retire
    instr_opcode = 6'h23;
    step("ab_f", 4'd0, E_FETCH);
    step("ab_d", 4'd1, E_DEC);
    step("ab_a", 4'd2, E_MADDR);
    mem_ready = 1'b0;
    #1;
    chk("ab_rd_state", 32'(state_dbg), 32'd3);
    rst = 1'b1;
    #1;
    chk("ab_rst_ctl", 32'(ctl), 32'(E_ZERO));
    @(posedge clk); #1;
    rst = 1'b0;
    mem_ready = 1'b1;
    chk("ab_cnt", 32'(retire_count), 32'd0);

    // 17 R-type instructions wrap the 4-bit counter to 1
    instr_opcode = 6'h00;
    for (int i = 0; i < 17; i++) begin
      step("wrap_f", 4'd0, E_FETCH);
      step("wrap_d", 4'd1, E_DEC);
      step("wrap_e", 4'd6, E_EXE);
      step("wrap_wb", 4'd7, E_RWB);
    end
    chk("wrap_cnt", 32'(retire_count), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl_fsm.md
# multicycle_ctrl_fsm

Multi-cycle sequencer for the CS161 MIPS datapath: replaces the single-cycle combinational control unit with a Moore-style state machine that steps each instruction through fetch, decode, execute, memory and write-back over 3–5+ cycles. It sits between the instruction register's opcode field and the multi-cycle datapath's enables and mux selects. It stalls on a memory-ready handshake and counts retired instructions for debug.

## Interface
- CNT_W, 32, width of the retired-instruction counter
- clk  in  1  clock; all state changes on the rising edge
- rst  in  1  reset; synchronous, active-high
- instr_opcode  in  6  opcode field of the IR (instruction bits 31:26)
- mem_ready  in  1  memory has completed the current read/write this cycle
- pc_write, pc_write_cond, ir_write, i_or_d  out  1 each  PC/IR enables and memory-address select (0=PC, 1=ALUOut)
- mem_read, mem_write  out  1 each  memory strobes, held until mem_ready
- reg_write, reg_dst, mem_to_reg  out  1 each  register-file control
- alu_src_a  out  1  0=PC, 1=A
- alu_src_b  out  2  00=B, 01=const 4, 10=sext imm, 11=sext imm<<2
- alu_op  out  2  00=add, 01=sub, 10=use funct (feeds the ALU control)
- pc_source  out  2  00=ALU result, 01=ALUOut, 10=jump target
- retire  out  1  one-cycle pulse on the final cycle of each instruction
- retire_count  out  CNT_W  retired instructions, wraps modulo 2^CNT_W
- state_dbg  out  4  current state encoding
- halted  out  1  illegal-opcode halt (only with the macro)

## Operation
- States and encodings: FETCH 0, DECODE 1, MEM_ADDR 2, MEM_READ 3, MEM_WB 4, MEM_WRITE 5, EXECUTE 6, R_WB 7, BRANCH 8, JUMP 9, ADDI_EX 10, ADDI_WB 11, HALT 15.
- Any output not listed for a state is 0.
- FETCH:
  - Outputs: mem_read=1, alu_src_b=01.
  - ir_write and pc_write equal mem_ready.
  - Stays in FETCH while mem_ready=0; moves to DECODE when mem_ready=1.
- DECODE:
  - Outputs: alu_src_b=11.
  - Branches on instr_opcode: 0x00→EXECUTE, 0x23/0x2B→MEM_ADDR, 0x04→BRANCH, 0x02→JUMP, 0x08→ADDI_EX, any other opcode→see Configuration.
- MEM_ADDR:
  - Outputs: alu_src_a=1, alu_src_b=10.
  - Next state: lw→MEM_READ, sw→MEM_WRITE.
- MEM_READ:
  - Outputs: mem_read=1, i_or_d=1.
  - Holds until mem_ready, then goes to MEM_WB.
- MEM_WB: reg_write=1, mem_to_reg=1; retire; next FETCH.
- MEM_WRITE:
  - Outputs: mem_write=1, i_or_d=1.
  - Holds until mem_ready; on the ready cycle, retire and go to FETCH.
- EXECUTE: alu_src_a=1, alu_op=10; next R_WB.
- R_WB: reg_write=1, reg_dst=1; retire; next FETCH.
- BRANCH: alu_src_a=1, alu_op=01, pc_write_cond=1, pc_source=01; retire; next FETCH.
- JUMP: pc_write=1, pc_source=10; retire; next FETCH.
- ADDI_EX: alu_src_a=1, alu_src_b=10; next ADDI_WB.
- ADDI_WB: reg_write=1; retire; next FETCH.
- retire_count increments by 1 on every cycle where retire=1, and wraps to 0 from all-ones.

## Timing
- Reset:
  - While rst=1, all control outputs, retire and halted are forced to 0.
  - On the rst edge: state becomes FETCH and retire_count becomes 0.
  - Reset asserted mid-instruction abandons it with no retire.
- instr_opcode is sampled only in DECODE.
- Latency with mem_ready held at 1: lw 5 cycles, sw/R/addi 4, beq/j 3. Each mem_ready=0 cycle in FETCH, MEM_READ or MEM_WRITE adds exactly one cycle.
- mem_read/mem_write stay stable and asserted across wait cycles.
- A mem_ready pulse outside a memory state is ignored.
- state_dbg is registered. All other outputs are combinational from state, plus mem_ready gating in FETCH and MEM_WRITE.

## Configuration
- MCTRL_ILLEGAL_TRAP_EN defined:
  - An unknown opcode in DECODE goes to HALT.
  - HALT asserts halted=1 and all other controls 0, stays until rst, and does not retire.
- MCTRL_ILLEGAL_TRAP_EN undefined:
  - An unknown opcode is a NOP: DECODE→FETCH with retire=1 on the DECODE cycle.
  - HALT is unreachable and halted is tied to 0.

## Structure
- Package mctrl_pkg holds:
  - the state enum (4-bit) and its encodings;
  - opcode constants OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI;
  - encodings for alu_op, alu_src_b and pc_source.
- Sub-module mctrl_out_decode: purely combinational, mapping (state, mem_ready, rst) to the control outputs.
- The top level keeps the state register, the next-state logic and the retire counter.

## Test plan
- Reset:
  - Hold rst for 2 cycles with mem_ready=1 → all outputs 0 during reset.
  - Cycle after rst falls: state_dbg=0, mem_read=1, ir_write=1, retire_count=0.
- lw, mem_ready=1:
  - Opcode 0x23 → state sequence 0,1,2,3,4,0.
  - reg_write=mem_to_reg=1 in state 4, retire pulse there, retire_count=1.
- lw with waits:
  - mem_ready low for 2 cycles in FETCH and 3 in MEM_READ → 10 cycles total.
  - ir_write high only on the ready cycle; mem_read steady throughout.
- beq then j:
  - Opcode 0x04 → 0,1,8 with pc_write_cond=1, pc_source=01.
  - Then opcode 0x02 → 0,1,9 with pc_write=1, pc_source=10.
  - retire_count increases by 2.
- Illegal opcode 0x3F:
  - With the macro: state_dbg=15, halted=1 until rst, no retire.
  - Without the macro: back to FETCH with one retire pulse.
- Counter wrap: CNT_W=4, run 17 R-type instructions → retire_count=1.
